// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: walks the shared datapath through
// FETCH, DECODE, EXEC, MEM and WB and drives every datapath enable and select.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        z,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        sel_addr,
  output logic        IR_WEN,
  output logic        PC_WEN,
  output logic        pc_src,
  output logic        AB_WEN,
  output logic        OUT_WEN,
  output logic        MDR_WEN,
  output logic        RF_WEN,
  output logic        sel_ld,
  output logic        sel_srcB,
  output logic [1:0]  sel_imm,
  output logic        sel_a,
  output logic        sel_comp,
  output logic [1:0]  sel_s,
  output logic [1:0]  sel_l,
  output logic [1:0]  sel_exec_out,
  output logic        br_taken,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_rtype, is_itype, is_load, is_store, is_branch, is_alu, is_legal;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign alt       = instr[30];
  assign is_rtype  = (opcode == 7'b0110011);
  assign is_itype  = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  // Every funct3 under the branch opcode behaves as BEQ.
  assign is_branch = (opcode == 7'b1100011);
  assign is_alu    = is_rtype | is_itype;
  assign is_legal  = is_alu | is_load | is_store | is_branch;

  // Register fields and immediate bits are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // State register; reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything stays 0 while rst is high.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    sel_addr     = 1'b0;
    IR_WEN       = 1'b0;
    PC_WEN       = 1'b0;
    pc_src       = 1'b0;
    AB_WEN       = 1'b0;
    OUT_WEN      = 1'b0;
    MDR_WEN      = 1'b0;
    RF_WEN       = 1'b0;
    sel_ld       = 1'b0;
    sel_srcB     = 1'b0;
    sel_imm      = 2'b00;
    sel_a        = 1'b0;
    sel_comp     = 1'b0;
    sel_s        = 2'b00;
    sel_l        = 2'b00;
    sel_exec_out = 2'b00;
    br_taken     = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IR_WEN  = 1'b1;
            PC_WEN  = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          AB_WEN = 1'b1;
          if (is_legal) begin
            state_d = StExec;
          end else begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        end
        StExec: begin
          if (is_alu) begin
            sel_srcB = ~opcode[5];
            OUT_WEN  = 1'b1;
            state_d  = StWb;
            case (funct3)
              3'b000: sel_a = opcode[5] & alt;
              3'b001: sel_exec_out = 2'b11;
              3'b010: begin
                sel_a        = 1'b1;
                sel_comp     = 1'b1;
                sel_exec_out = 2'b01;
              end
              3'b011: begin
                sel_a        = 1'b1;
                sel_exec_out = 2'b01;
              end
              3'b100: sel_exec_out = 2'b10;
              3'b101: begin
                sel_s        = alt ? 2'b11 : 2'b10;
                sel_exec_out = 2'b11;
              end
              3'b110: begin
                sel_l        = 2'b01;
                sel_exec_out = 2'b10;
              end
              default: begin
                sel_l        = 2'b10;
                sel_exec_out = 2'b10;
              end
            endcase
          end else if (is_load || is_store) begin
            sel_srcB = 1'b1;
            sel_imm  = is_store ? 2'b01 : 2'b00;
            OUT_WEN  = 1'b1;
            state_d  = StMem;
          end else if (is_branch) begin
            sel_imm  = 2'b10;
            sel_a    = 1'b1;
            br_taken = z;
            PC_WEN   = z;
            pc_src   = z;
            retire   = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StFetch;
          end
        end
        StMem: begin
          // Address/format selects held steady for the whole request.
          mem_req  = 1'b1;
          sel_addr = 1'b1;
          mem_we   = is_store;
          sel_imm  = is_store ? 2'b01 : 2'b00;
          if (mem_ready) begin
            if (is_store) begin
              retire  = 1'b1;
              state_d = StFetch;
            end else begin
              MDR_WEN = 1'b1;
              state_d = StWb;
            end
          end
        end
        StWb: begin
          RF_WEN  = 1'b1;
          sel_ld  = is_load;
          retire  = 1'b1;
          state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

endmodule
